// File: rtl/fp_issue_queue.sv
// Instruction FIFO and hazard-aware issue stage feeding the FPU 'ins' input.
// A per-register countdown scoreboard holds back RAW/WAW hazards and ADD/SUB-after-MUL writeback clashes.
module fp_issue_queue #(
  parameter int unsigned DEPTH   = 8,
  parameter int unsigned LAT_ADD = 5,
  parameter int unsigned LAT_MUL = 6,
  parameter int unsigned LAT_LD  = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  input  logic [23:0]            in_ins,
  output logic                   in_ready,
  input  logic                   flush,
  output logic [23:0]            ins_out,
  output logic                   issued,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic [15:0]            stall_cnt,
  output logic                   busy
);
  localparam int unsigned AW   = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  // Counters hold cycles still unreadable, so a dependant issues exactly LAT cycles later.
  localparam logic [2:0] SB_ADD = 3'(LAT_ADD - 1);
  localparam logic [2:0] SB_MUL = 3'(LAT_MUL - 1);
  localparam logic [2:0] SB_LD  = 3'(LAT_LD - 1);

  typedef enum logic [3:0] {
    OP_NOP = 4'd0, OP_ADD = 4'd1, OP_SUB = 4'd2, OP_MUL = 4'd3,
    OP_LD  = 4'd4, OP_SD  = 4'd5, OP_CMP = 4'd6
  } op_e;

  logic [23:0]   mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [AW:0]   count;
  logic [2:0]    sb [32];
  logic          mul_last;

  logic [23:0] head;
  logic [3:0]  op;
  logic [4:0]  rd, rs1, rs2;
  logic        is_arith, is_mul, is_ld, is_sd, is_cmp, known, writes;
  logic        busy_rd, busy_rs1, busy_rs2;
  logic        raw, waw, hold, empty, do_push, do_pop, sb_any;
  logic [2:0]  sb_load;

  always_comb begin
    head     = mem[rd_ptr];
    op       = head[23:20];
    rd       = head[19:15];
    rs1      = head[14:10];
    rs2      = head[9:5];
    is_arith = (op == OP_ADD) || (op == OP_SUB);
    is_mul   = (op == OP_MUL);
    is_ld    = (op == OP_LD);
    is_sd    = (op == OP_SD);
    is_cmp   = (op == OP_CMP);
    known    = is_arith | is_mul | is_ld | is_sd | is_cmp;
    writes   = is_arith | is_mul | is_ld;
    sb_load  = is_arith ? SB_ADD : (is_mul ? SB_MUL : SB_LD);
    busy_rd  = (sb[rd]  != 3'd0);
    busy_rs1 = (sb[rs1] != 3'd0);
    busy_rs2 = (sb[rs2] != 3'd0);
    raw      = ((is_arith | is_mul | is_cmp) & (busy_rs1 | busy_rs2)) | (is_sd & busy_rs1);
    waw      = writes & busy_rd;
    hold     = raw | waw | (is_arith & mul_last);
    empty    = (count == '0);
    in_ready = (count < FULL);
    do_push  = in_valid & in_ready & ~flush;
    do_pop   = ~flush & ~empty & ~hold;
  end

  always_comb begin
    sb_any = 1'b0;
    for (int unsigned i = 0; i < 32; i++) sb_any = sb_any | (sb[i] != 3'd0);
  end

  assign fifo_count = count;
  assign busy       = ~empty | sb_any;

  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      ins_out   <= '0;
      issued    <= 1'b0;
      stall_cnt <= '0;
      mul_last  <= 1'b0;
      for (int unsigned i = 0; i < 32; i++) sb[i] <= '0;
    end else begin
      if (flush) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
      end else begin
        if (do_push) wr_ptr <= wr_ptr + AW'(1);
        if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
        if (do_push && !do_pop)      count <= count + (AW+1)'(1);
        else if (!do_push && do_pop) count <= count - (AW+1)'(1);
      end
      ins_out  <= (do_pop && known) ? head : '0;
      issued   <= do_pop;
      mul_last <= do_pop & is_mul;
      if (!flush && !empty && hold && stall_cnt != '1) stall_cnt <= stall_cnt + 16'd1;
      for (int unsigned i = 0; i < 32; i++) begin
        if (do_pop && writes && rd == 5'(i)) sb[i] <= sb_load;
        else if (sb[i] != 3'd0)              sb[i] <= sb[i] - 3'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst && do_push) mem[wr_ptr] <= in_ins;
  end
endmodule
